// File: rtl/freq_div_ctrl.sv
// Run-time controller for the frequency divider: owns the divide counter and the
// divided clock, and retunes or stops it only at output period boundaries.
module freq_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic             i_cfg_en,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_out_clk,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_div_active,
    output logic             o_err_div
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP_WAIT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_active;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_out_clk;
    logic             r_err_div;

    logic             w_xfer;
    logic             w_div_bad;
    logic             w_boundary;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W:0]   w_half;
    logic [CNT_W-1:0] w_step_cnt;
    logic             w_step_out;

    assign w_xfer     = i_cfg_valid && o_cfg_ready;
    assign w_div_bad  = (i_cfg_div < CNT_W'(2));
    assign w_boundary = (r_cnt == (r_div_active - CNT_W'(1)));
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // High time is ceil(N/2); the extra bit keeps N = 2^CNT_W-1 from overflowing.
    assign w_half     = ({1'b0, r_div_active} + (CNT_W+1)'(1)) >> 1;

    assign w_step_cnt = w_boundary ? '0 : w_cnt_inc;
    assign w_step_out = w_boundary ? 1'b1 : ({1'b0, w_cnt_inc} < w_half);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_out_clk    <= 1'b0;
            r_err_div    <= 1'b0;
            r_div_active <= CNT_W'(DEFAULT_DIV);
            r_pend_div   <= '0;
        end else begin
            r_err_div <= w_xfer && w_div_bad;
            case (r_state)
                IDLE: begin
                    if (w_xfer && !w_div_bad && i_cfg_en) begin
                        r_div_active <= i_cfg_div;
                        r_cnt        <= '0;
                        r_out_clk    <= 1'b1;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    r_cnt     <= w_step_cnt;
                    r_out_clk <= w_step_out;
                    // Commands are only latched here; they take effect at the next boundary.
                    if (w_xfer && !w_div_bad) begin
                        if (i_cfg_en) begin
                            r_pend_div <= i_cfg_div;
                            r_state    <= PEND;
                        end else begin
                            r_state <= STOP_WAIT;
                        end
                    end
                end
                PEND: begin
                    if (w_boundary) begin
                        r_div_active <= r_pend_div;
                        r_cnt        <= '0;
                        r_out_clk    <= 1'b1;
                        r_state      <= RUN;
                    end else begin
                        r_cnt     <= w_step_cnt;
                        r_out_clk <= w_step_out;
                    end
                end
                STOP_WAIT: begin
                    if (w_boundary) begin
                        r_cnt     <= '0;
                        r_out_clk <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt     <= w_step_cnt;
                        r_out_clk <= w_step_out;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cfg_ready  = (r_state == IDLE) || (r_state == RUN);
    assign o_busy       = (r_state != IDLE);
    assign o_out_clk    = r_out_clk;
    assign o_div_active = r_div_active;
    assign o_err_div    = r_err_div;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: directed scenarios plus random commands,
// compared every cycle against a waveform-queue reference model.
module tb_freq_div_ctrl;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             clk = 1'b0;
    logic             rstN;
    logic             cfgValid;
    logic             cfgReady;
    logic             cfgEn;
    logic [CNT_W-1:0] cfgDiv;
    logic             outClk;
    logic             busy;
    logic [CNT_W-1:0] divActive;
    logic             errDiv;

    int checks = 0;
    int errors = 0;

    typedef enum {M_IDLE, M_RUN, M_PEND, M_STOP} mstate_t;
    mstate_t mState;
    int      mDiv;
    int      mPend;
    bit      mErr;
    // Remaining out_clk values of the current period; front is what is shown now.
    bit      waveQ[$];

    freq_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_cfg_valid  (cfgValid),
        .o_cfg_ready  (cfgReady),
        .i_cfg_en     (cfgEn),
        .i_cfg_div    (cfgDiv),
        .o_out_clk    (outClk),
        .o_busy       (busy),
        .o_div_active (divActive),
        .o_err_div    (errDiv)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushPeriod(input int n);
        for (int i = 0; i < n; i++) waveQ.push_back(i < (n + 1) / 2);
    endtask

    task automatic modelReset();
        mState = M_IDLE;
        mDiv   = DEFAULT_DIV;
        mPend  = 0;
        mErr   = 1'b0;
        waveQ.delete();
    endtask

    // One rising edge worth of behaviour, using the inputs present at that edge.
    task automatic modelEdge();
        bit ready;
        bit xfer;
        bit bad;
        ready = (mState == M_IDLE) || (mState == M_RUN);
        xfer  = cfgValid && ready;
        bad   = (int'(cfgDiv) < 2);
        mErr  = xfer && bad;
        if (mState != M_IDLE) begin
            void'(waveQ.pop_front());
            if (waveQ.size() == 0) begin
                case (mState)
                    M_PEND: begin mDiv = mPend; mState = M_RUN; end
                    M_STOP: mState = M_IDLE;
                    default: ;
                endcase
                if (mState != M_IDLE) pushPeriod(mDiv);
            end
        end
        if (xfer && !bad) begin
            case (mState)
                M_IDLE: if (cfgEn) begin
                    mDiv = int'(cfgDiv);
                    waveQ.delete();
                    pushPeriod(mDiv);
                    mState = M_RUN;
                end
                M_RUN: begin
                    if (cfgEn) begin mPend = int'(cfgDiv); mState = M_PEND; end
                    else mState = M_STOP;
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkAll();
        bit expOut;
        expOut = (mState == M_IDLE) ? 1'b0 : waveQ[0];
        checkOutput("out_clk", outClk, expOut);
        checkOutput("busy", busy, (mState != M_IDLE));
        checkOutput("cfg_ready", cfgReady, (mState == M_IDLE) || (mState == M_RUN));
        checkOutput("div_active", divActive, mDiv);
        checkOutput("err_div", errDiv, mErr);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic applyStimulus(input bit en, input int div);
        cfgValid = 1'b1;
        cfgEn    = en;
        cfgDiv   = CNT_W'(div);
        tick();
        cfgValid = 1'b0;
    endtask

    // Waits (bounded) until the model shows a running period at the given counter position.
    task automatic waitForCnt(input int cnt, input string tag);
        int budget;
        budget = 600;
        while (!(mState == M_RUN && waveQ.size() == mDiv - cnt) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) checkOutput(tag, 0, 1);
    endtask

    task automatic asyncReset();
        cfgValid = 1'b0;
        #3;
        rstN = 1'b0;
        modelReset();
        #1;
        checkAll();
        repeat (2) begin
            @(posedge clk);
            #1;
            checkAll();
        end
        #2;
        rstN = 1'b1;
    endtask

    initial begin
        int highCnt;
        rstN     = 1'b0;
        cfgValid = 1'b0;
        cfgEn    = 1'b0;
        cfgDiv   = '0;
        modelReset();
        repeat (3) begin
            @(posedge clk);
            #1;
            checkAll();
        end
        rstN = 1'b1;
        repeat (2) tick();

        applyStimulus(1'b1, 4);
        repeat (8) tick();

        waitForCnt(1, "wait_cnt1_retune");
        applyStimulus(1'b1, 3);
        repeat (12) tick();

        applyStimulus(1'b1, 4);
        repeat (6) tick();
        applyStimulus(1'b1, 1);
        repeat (3) tick();
        applyStimulus(1'b0, 0);
        repeat (5) tick();

        waitForCnt(0, "wait_cnt0_stop");
        applyStimulus(1'b0, 7);
        repeat (8) tick();
        applyStimulus(1'b0, 5);
        repeat (2) tick();

        applyStimulus(1'b1, 4);
        waitForCnt(1, "wait_high_reset");
        asyncReset();
        repeat (3) tick();

        applyStimulus(1'b1, 255);
        highCnt = int'(outClk);
        repeat (254) begin
            tick();
            highCnt += int'(outClk);
        end
        checkOutput("high_cycles_255", highCnt, 128);
        tick();
        checkOutput("period_restart_255", outClk, 1);

        repeat (3000) begin
            int r;
            if ($urandom_range(0, 499) == 0) begin
                asyncReset();
            end
            cfgValid = ($urandom_range(0, 5) == 0);
            cfgEn    = ($urandom_range(0, 4) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)      cfgDiv = CNT_W'($urandom_range(0, 1));
            else if (r == 1) cfgDiv = CNT_W'(255);
            else             cfgDiv = CNT_W'($urandom_range(2, 9));
            tick();
        end
        cfgValid = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
